mem_req_sequencer: RTL and testbench

MEM_REQ_SEQUENCER -- requirements
Module: mem_req_sequencer

---
 rtl/mem_req_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_mem_req_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mem_req_sequencer
//  Description : Buffers read/write commands in a small FIFO and issues them
//                one at a time to a memory port. Each command waits for a
//                completion pulse or a timeout, then returns one response.
//                Responses come back in command order.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_req_sequencer #(
    parameter int DEPTH   = 4,     // command FIFO entries, power of 2, >= 2
    parameter int TIMEOUT = 16     // max cycles waited for mem_ready
) (
    input  logic        clk,
    input  logic        rst,
    // command channel
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_wr_rd,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    // memory channel
    output logic        mem_valid,
    output logic        mem_wr_rd,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic        mem_error,
    input  logic [31:0] mem_rdata,
    // response channel
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_wr_rd,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        rsp_timeout
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int EW = 65;             // {wr_rd, addr, wdata}

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [EW-1:0]   fifo_mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [TW-1:0]   w_timer_inc;

    logic            req_wr_rd_q, req_wr_rd_d;
    logic [31:0]     req_addr_q, req_addr_d;
    logic [31:0]     req_wdata_q, req_wdata_d;

    logic            rsp_wr_rd_q, rsp_wr_rd_d;
    logic [31:0]     rsp_rdata_q, rsp_rdata_d;
    logic            rsp_error_q, rsp_error_d;
    logic            rsp_timeout_q, rsp_timeout_d;

    logic            w_full, w_empty, w_push, w_pop;

    // Full flag comes from the registered count only, so cmd_ready never
    // depends combinationally on the response side.
    assign w_full    = (count_q == CW'(DEPTH));
    assign w_empty   = (count_q == '0);
    assign cmd_ready = !w_full;
    assign w_push    = cmd_valid && !w_full;

    assign mem_valid   = (state_q == S_ISSUE);
    assign mem_wr_rd   = req_wr_rd_q;
    assign mem_addr    = req_addr_q;
    assign mem_wdata   = req_wdata_q;

    assign rsp_valid   = (state_q == S_RESP);
    assign rsp_wr_rd   = rsp_wr_rd_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_error   = rsp_error_q;
    assign rsp_timeout = rsp_timeout_q;

    assign w_timer_inc = timer_q + 1'b1;

    // FIFO storage: written on accepted commands, contents need no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_mem_q[wr_ptr_q] <= {cmd_wr_rd, cmd_addr, cmd_wdata};
        end
    end

    // FIFO occupancy bookkeeping.
    always_comb begin
        count_d = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Sequencer next-state, request latch and response capture.
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        w_pop         = 1'b0;
        req_wr_rd_d   = req_wr_rd_q;
        req_addr_d    = req_addr_q;
        req_wdata_d   = req_wdata_q;
        rsp_wr_rd_d   = rsp_wr_rd_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_error_d   = rsp_error_q;
        rsp_timeout_d = rsp_timeout_q;
        case (state_q)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    req_wr_rd_d = fifo_mem_q[rd_ptr_q][64];
                    req_addr_d  = fifo_mem_q[rd_ptr_q][63:32];
                    req_wdata_d = fifo_mem_q[rd_ptr_q][31:0];
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem_ready) begin
                    rsp_wr_rd_d   = req_wr_rd_q;
                    rsp_error_d   = mem_error;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = (!req_wr_rd_q && !mem_error) ? mem_rdata : 32'd0;
                    state_d       = S_RESP;
                end else if (w_timer_inc == TW'(TIMEOUT)) begin
                    // TIMEOUT full WAIT cycles elapsed with no completion.
                    rsp_wr_rd_d   = req_wr_rd_q;
                    rsp_error_d   = 1'b0;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = 32'd0;
                    state_d       = S_RESP;
                end else begin
                    timer_d = w_timer_inc;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, pointers and all control/data registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            timer_q       <= '0;
            req_wr_rd_q   <= 1'b0;
            req_addr_q    <= 32'd0;
            req_wdata_q   <= 32'd0;
            rsp_wr_rd_q   <= 1'b0;
            rsp_rdata_q   <= 32'd0;
            rsp_error_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            timer_q       <= timer_d;
            req_wr_rd_q   <= req_wr_rd_d;
            req_addr_q    <= req_addr_d;
            req_wdata_q   <= req_wdata_d;
            rsp_wr_rd_q   <= rsp_wr_rd_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_error_q   <= rsp_error_d;
            rsp_timeout_q <= rsp_timeout_d;
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_req_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_req_sequencer
//  Description : Directed self-checking bench for mem_req_sequencer with a
//                small behavioural memory (1-cycle completion or silent).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_req_sequencer;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_wr_rd;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        mem_valid, mem_wr_rd;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready, mem_error;
    logic [31:0] mem_rdata;
    logic        rsp_valid, rsp_ready, rsp_wr_rd, rsp_error, rsp_timeout;
    logic [31:0] rsp_rdata;

    logic        mdl_ready, spur_ready;
    logic        pend;
    int          mode = 0;          // 0: answer next cycle, 1: never answer
    logic [31:0] mem [16];

    int n_cmp = 0;
    int n_mis = 0;

    assign mem_ready = mdl_ready | spur_ready;

    always #5 clk = ~clk;

    mem_req_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr_rd(cmd_wr_rd),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .mem_valid(mem_valid), .mem_wr_rd(mem_wr_rd), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_error(mem_error),
        .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr_rd(rsp_wr_rd),
        .rsp_rdata(rsp_rdata), .rsp_error(rsp_error), .rsp_timeout(rsp_timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Memory: completes one cycle after the ISSUE strobe; >=1024 is an error.
    // Junk rdata on writes/errors makes sure the DUT zeroes rsp_rdata there.
    initial begin
        mdl_ready = 1'b0;
        mem_error = 1'b0;
        mem_rdata = 32'd0;
        pend      = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 32'hA000_0000 + i;
        forever begin
            @(negedge clk);
            mdl_ready = 1'b0;
            mem_error = 1'b0;
            if (pend && mode == 0) begin
                mdl_ready = 1'b1;
                if (mem_addr >= 32'd1024) begin
                    mem_error = 1'b1;
                    mem_rdata = 32'hFFFF_FFFF;
                end else if (mem_wr_rd) begin
                    mem[mem_addr[3:0]] = mem_wdata;
                    mem_rdata = 32'h1234_5678;
                end else begin
                    mem_rdata = mem[mem_addr[3:0]];
                end
            end
            pend = mem_valid && !rst;
        end
    end

    task automatic push(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_wr_rd = wr;
        cmd_addr  = addr;
        cmd_wdata = data;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check("push_accept", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Waits for rsp_valid; reports cycles waited, ISSUE strobes seen and
    // the wait index at which the first strobe was seen.
    task automatic wait_rsp(input int bound, output int lat, output int pulses, output int issue_at);
        lat = 0; pulses = 0; issue_at = -1;
        while (!rsp_valid && lat < bound) begin
            if (mem_valid) begin
                pulses++;
                if (issue_at < 0) issue_at = lat;
            end
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) check("rsp_wait", 32'(rsp_valid), 32'd1);
    endtask

    task automatic take_rsp(input string tag, input logic wr, input logic [31:0] rd,
                            input logic err, input logic to);
        check({tag, "_wr"},  32'(rsp_wr_rd),   32'(wr));
        check({tag, "_rd"},  rsp_rdata,        rd);
        check({tag, "_err"}, 32'(rsp_error),   32'(err));
        check({tag, "_to"},  32'(rsp_timeout), 32'(to));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, pul, ia;
        logic seen;
        rst = 1'b1; cmd_valid = 1'b0; cmd_wr_rd = 1'b0;
        cmd_addr = 32'd0; cmd_wdata = 32'd0; rsp_ready = 1'b0; spur_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_mem_addr",  mem_addr,       32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);

        // Write then read back, with minimum latency (accept, pop, issue, capture).
        push(1'b1, 32'd5, 32'hDEAD_BEEF);
        wait_rsp(100, lat, pul, ia);
        check("lat_min", lat, 3);
        check("wr5_pulses", pul, 1);
        take_rsp("wr5", 1'b1, 32'd0, 1'b0, 1'b0);
        push(1'b0, 32'd5, 32'd0);
        wait_rsp(100, lat, pul, ia);
        check("rd5_pulses", pul, 1);
        take_rsp("rd5", 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);

        // Out-of-range read.
        push(1'b0, 32'd1024, 32'd0);
        wait_rsp(100, lat, pul, ia);
        check("rd1024_pulses", pul, 1);
        take_rsp("rd1024", 1'b0, 32'd0, 1'b1, 1'b0);

        // Five back-to-back commands with back-pressure: one in flight + DEPTH queued.
        push(1'b1, 32'd1, 32'd11);
        push(1'b1, 32'd2, 32'd22);
        push(1'b0, 32'd1, 32'd0);
        push(1'b0, 32'd2, 32'd0);
        push(1'b0, 32'd3, 32'd0);
        check("full_cmd_ready", 32'(cmd_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            check("hold_rsp_wr",    32'(rsp_wr_rd), 32'd1);
            check("hold_mem_valid", 32'(mem_valid), 32'd0);
            @(negedge clk);
        end
        take_rsp("q0", 1'b1, 32'd0, 1'b0, 1'b0);
        wait_rsp(100, lat, pul, ia);
        take_rsp("q1", 1'b1, 32'd0, 1'b0, 1'b0);
        wait_rsp(100, lat, pul, ia);
        take_rsp("q2", 1'b0, 32'd11, 1'b0, 1'b0);
        wait_rsp(100, lat, pul, ia);
        take_rsp("q3", 1'b0, 32'd22, 1'b0, 1'b0);
        wait_rsp(100, lat, pul, ia);
        take_rsp("q4", 1'b0, 32'hA000_0003, 1'b0, 1'b0);

        // Silent memory: ISSUE cycle plus TIMEOUT WAIT cycles, then the
        // queued write goes out normally.
        mode = 1;
        push(1'b0, 32'd7, 32'd0);
        push(1'b1, 32'd3, 32'd33);
        wait_rsp(TIMEOUT + 40, lat, pul, ia);
        check("to_delay", lat - ia, TIMEOUT + 1);
        check("to_pulses", pul, 1);
        mode = 0;
        take_rsp("to7", 1'b0, 32'd0, 1'b0, 1'b1);
        wait_rsp(100, lat, pul, ia);
        check("wr3_pulses", pul, 1);
        take_rsp("wr3", 1'b1, 32'd0, 1'b0, 1'b0);

        // Spurious completion while idle.
        spur_ready = 1'b1;
        @(negedge clk);
        spur_ready = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | rsp_valid | mem_valid;
        end
        check("spur_none", 32'(seen), 32'd0);

        // Reset in WAIT with two commands queued; late completion afterwards.
        mode = 1;
        push(1'b0, 32'd9,  32'h99);
        push(1'b1, 32'd10, 32'd1);
        push(1'b1, 32'd11, 32'd2);
        repeat (3) @(negedge clk);
        check("inflight_addr",  mem_addr,  32'd9);
        check("inflight_wdata", mem_wdata, 32'h99);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mode = 0;
        spur_ready = 1'b1;
        @(negedge clk);
        spur_ready = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen = seen | rsp_valid | mem_valid;
        end
        check("rst_no_activity", 32'(seen),        32'd0);
        check("rst_cmd_ready",   32'(cmd_ready),   32'd1);
        check("rst_addr",        mem_addr,         32'd0);
        check("rst_wdata",       mem_wdata,        32'd0);
        check("rst_mem_wr",      32'(mem_wr_rd),   32'd0);
        check("rst_rsp_wr",      32'(rsp_wr_rd),   32'd0);
        check("rst_rsp_rdata",   rsp_rdata,        32'd0);
        check("rst_rsp_err",     32'(rsp_error),   32'd0);
        check("rst_rsp_to",      32'(rsp_timeout), 32'd0);

        // Normal operation resumes after reset.
        push(1'b0, 32'd3, 32'd0);
        wait_rsp(100, lat, pul, ia);
        check("post_rst_lat", lat, 3);
        take_rsp("post_rst", 1'b0, 32'd33, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
